// File: rtl/morphle_vector_checker.sv
// rtl/morphle_vector_checker.sv - on-chip stimulus/response vector checker for Morphle yblock arrays
//
// Purpose:
//   Vectors {mask, expected, stimulus} are preloaded into internal storage.
//   When a run starts, each vector goes through three steps:
//     1. Its stimulus is driven onto dut_in.
//     2. The asynchronous array is given SETTLE cycles to settle.
//     3. dut_out is compared with the expected response.
//   A set mask bit means don't care. The block reports an error count, the
//   first failing index and pass/done.
//
// Optional feature:
//   Define MORPHLE_VCHK_SIG_EN to add the sig output. It is a rotate-and-xor
//   signature of the masked responses, collected in every CHECK step.
//
// Ports:
//   wb_clk_i          clock
//   wb_rst_i          synchronous active-high reset
//   wr_en/wr_addr     write one vector word into storage (dropped while busy)
//   wr_data           {mask, expected, stimulus}, stimulus in the LSBs
//   start             one-cycle pulse that begins a run (ignored while busy)
//   num_vec           number of vectors to run, 0..DEPTH (larger values clamp)
//   dut_in            stimulus driven to the array
//   dut_out           response sampled from the array
//   busy              run in progress
//   done              run complete, held until the next start
//   pass              done with zero mismatches
//   err_count         mismatching vectors, saturating
//   first_fail        index of the first mismatching vector
//   first_fail_valid  first_fail holds a real index
//   cur_index         vector currently applied
//   sig               response signature (only with MORPHLE_VCHK_SIG_EN)

module morphle_vector_checker #(
    parameter int STIM_W = 52,
    parameter int RESP_W = 48,
    parameter int DEPTH  = 256,
    parameter int SETTLE = 4,
    parameter int ERR_W  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int VW    = STIM_W + 2 * RESP_W
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [VW-1:0]     wr_data,
    input  logic              start,
    input  logic [AW:0]       num_vec,
    output logic [STIM_W-1:0] dut_in,
    input  logic [RESP_W-1:0] dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [AW-1:0]     first_fail,
    output logic              first_fail_valid,
    output logic [AW-1:0]     cur_index
`ifdef MORPHLE_VCHK_SIG_EN
    ,
    output logic [RESP_W-1:0] sig
`endif
);

    localparam int SCW = $clog2(SETTLE + 1);
    localparam logic [AW:0]    DEPTH_N    = (AW + 1)'(DEPTH);
    localparam logic [AW:0]    ONE_N      = (AW + 1)'(1);
    localparam logic [SCW-1:0] SETTLE_TOP = SCW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t r_state;

    logic [VW-1:0]     r_mem [DEPTH];
    logic [STIM_W-1:0] r_dut_in;
    logic [RESP_W-1:0] r_exp;
    logic [RESP_W-1:0] r_mask;
    logic [AW:0]       r_n;
    logic [SCW-1:0]    r_settle_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [ERR_W-1:0]  r_err_count;
    logic [AW-1:0]     r_first_fail;
    logic              r_first_fail_valid;
    logic [AW-1:0]     r_cur_index;
`ifdef MORPHLE_VCHK_SIG_EN
    logic [RESP_W-1:0] r_sig;
`endif

    logic              w_wr;
    logic              w_start_ok;
    logic [AW:0]       w_n_clamped;
    logic              w_mismatch;
    logic [ERR_W-1:0]  w_err_next;
    logic              w_last;

    // Storage writes are locked out for the whole run so a run always sees a
    // consistent vector set.
    assign w_wr        = wr_en && !r_busy;
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_n_clamped = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;

    // A mask bit of 1 removes that response bit from the comparison.
    assign w_mismatch = |((dut_out ^ r_exp) & ~r_mask);
    assign w_err_next = (w_mismatch && !(&r_err_count)) ? r_err_count + ERR_W'(1) : r_err_count;
    assign w_last     = ({1'b0, r_cur_index} == (r_n - ONE_N));

    // Storage has no reset: vectors survive a reset of the checker.
    always_ff @(posedge wb_clk_i) begin
        if (w_wr) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state            <= S_IDLE;
            r_dut_in           <= '0;
            r_exp              <= '0;
            r_mask             <= '0;
            r_n                <= '0;
            r_settle_cnt       <= '0;
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
            r_pass             <= 1'b0;
            r_err_count        <= '0;
            r_first_fail       <= '0;
            r_first_fail_valid <= 1'b0;
            r_cur_index        <= '0;
`ifdef MORPHLE_VCHK_SIG_EN
            r_sig              <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        r_n                <= w_n_clamped;
                        r_err_count        <= '0;
                        r_first_fail       <= '0;
                        r_first_fail_valid <= 1'b0;
                        r_cur_index        <= '0;
`ifdef MORPHLE_VCHK_SIG_EN
                        r_sig              <= '0;
`endif
                        if (w_n_clamped == '0) begin
                            // Empty run: finish at once and leave dut_in untouched.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_APPLY;
                            r_done  <= 1'b0;
                            r_pass  <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                S_APPLY: begin
                    // Registered read. The stimulus field lands directly in the
                    // dut_in register, so the array sees it as SETTLE begins.
                    r_dut_in     <= r_mem[r_cur_index][STIM_W-1:0];
                    r_exp        <= r_mem[r_cur_index][STIM_W +: RESP_W];
                    r_mask       <= r_mem[r_cur_index][STIM_W+RESP_W +: RESP_W];
                    r_settle_cnt <= SETTLE_TOP;
                    r_state      <= S_SETTLE;
                end

                S_SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - SCW'(1);
                    end
                end

                S_CHECK: begin
                    r_err_count <= w_err_next;
                    if (w_mismatch && !r_first_fail_valid) begin
                        r_first_fail       <= r_cur_index;
                        r_first_fail_valid <= 1'b1;
                    end
`ifdef MORPHLE_VCHK_SIG_EN
                    r_sig <= {r_sig[RESP_W-2:0], r_sig[RESP_W-1]} ^ (dut_out & ~r_mask);
`endif
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                    end else begin
                        r_cur_index <= r_cur_index + AW'(1);
                        r_state     <= S_APPLY;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dut_in           = r_dut_in;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err_count;
    assign first_fail       = r_first_fail;
    assign first_fail_valid = r_first_fail_valid;
    assign cur_index        = r_cur_index;
`ifdef MORPHLE_VCHK_SIG_EN
    assign sig              = r_sig;
`endif

endmodule

// File: tb/tb_morphle_vector_checker.sv
// tb/tb_morphle_vector_checker.sv - self-checking bench for morphle_vector_checker
module tb_morphle_vector_checker;

    localparam int STIM_W = 52;
    localparam int RESP_W = 48;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int DEPTH2 = 8;
    localparam int WD     = STIM_W + 2 * RESP_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              wr_en1, wr_en2, start1, start2;
    logic [AW-1:0]     wr_addr;
    logic [WD-1:0]     wr_data;
    logic [AW:0]       num_vec;

    logic [STIM_W-1:0] dut_in1, dut_in2;
    logic              busy1, done1, pass1, ffv1;
    logic              busy2, done2, pass2, ffv2;
    logic [15:0]       err1;
    logic [1:0]        err2;
    logic [3:0]        ff1, cur1;
    logic [2:0]        ff2, cur2;
`ifdef MORPHLE_VCHK_SIG_EN
    logic [RESP_W-1:0] sig1, sig2;
`endif

    morphle_vector_checker #(.STIM_W(STIM_W), .RESP_W(RESP_W), .DEPTH(DEPTH), .SETTLE(4), .ERR_W(16)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wr_en(wr_en1), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start1), .num_vec(num_vec), .dut_in(dut_in1), .dut_out(dut_in1[RESP_W-1:0]),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_fail(ff1),
        .first_fail_valid(ffv1), .cur_index(cur1)
`ifdef MORPHLE_VCHK_SIG_EN
        , .sig(sig1)
`endif
    );

    morphle_vector_checker #(.STIM_W(STIM_W), .RESP_W(RESP_W), .DEPTH(DEPTH2), .SETTLE(4), .ERR_W(2)) u_dut2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wr_en(wr_en2), .wr_addr(wr_addr[2:0]), .wr_data(wr_data),
        .start(start2), .num_vec(num_vec[3:0]), .dut_in(dut_in2), .dut_out(dut_in2[RESP_W-1:0]),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .first_fail(ff2),
        .first_fail_valid(ffv2), .cur_index(cur2)
`ifdef MORPHLE_VCHK_SIG_EN
        , .sig(sig2)
`endif
    );

    // Selected-instance view of the outputs.
    int                sel = 0;
    logic [STIM_W-1:0] m_dut_in;
    logic              m_busy, m_done, m_pass, m_ffv;
    logic [15:0]       m_err;
    logic [3:0]        m_ff, m_cur;
    logic [RESP_W-1:0] m_sig;

    always_comb begin
        m_dut_in = (sel != 0) ? dut_in2 : dut_in1;
        m_busy   = (sel != 0) ? busy2 : busy1;
        m_done   = (sel != 0) ? done2 : done1;
        m_pass   = (sel != 0) ? pass2 : pass1;
        m_ffv    = (sel != 0) ? ffv2 : ffv1;
        m_err    = (sel != 0) ? {14'h0, err2} : err1;
        m_ff     = (sel != 0) ? {1'b0, ff2} : ff1;
        m_cur    = (sel != 0) ? {1'b0, cur2} : cur1;
        m_sig    = '0;
`ifdef MORPHLE_VCHK_SIG_EN
        m_sig    = (sel != 0) ? sig2 : sig1;
`endif
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [WD-1:0] mdl1 [DEPTH];
    logic [WD-1:0] mdl2 [DEPTH2];

    int                g_cycles;
    bit                g_busy;
    logic [STIM_W-1:0] g_prev_in;
    logic [RESP_W-1:0] g_sig_start;

    typedef struct {
        int          nv;
        logic [15:0] flips;
        logic [15:0] masks;
        int          e_err;
        int          e_ff;
        bit          e_ffv;
        bit          e_pass;
        int          e_cyc;
    } row_t;

    row_t rows [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [STIM_W-1:0] stim_of(input int i);
        logic [STIM_W-1:0] b;
        logic [STIM_W-1:0] k;
        b = 52'h3_1416_5926_5358;
        k = STIM_W'(i + 1);
        return (b * k) ^ {k[7:0], 44'h0};
    endfunction

    function automatic logic [WD-1:0] mkw(input logic [STIM_W-1:0] st, input logic [RESP_W-1:0] ex,
                                          input logic [RESP_W-1:0] mk);
        return {mk, ex, st};
    endfunction

    task automatic write_vec(input int s, input int addr, input logic [WD-1:0] d);
        wr_addr = AW'(addr);
        wr_data = d;
        if (s != 0) wr_en2 = 1'b1; else wr_en1 = 1'b1;
        @(posedge clk);
        #1;
        wr_en1 = 1'b0;
        wr_en2 = 1'b0;
        if (s != 0) mdl2[addr] = d; else mdl1[addr] = d;
    endtask

    // Loopback response equals stim[47:0]; a flip bit corrupts expected bit 5,
    // a mask bit marks response bit 5 as don't care.
    task automatic load(input int s, input int count, input logic [15:0] flips, input logic [15:0] masks);
        logic [STIM_W-1:0] st;
        for (int i = 0; i < count; i++) begin
            st = stim_of(i);
            write_vec(s, i, mkw(st, st[RESP_W-1:0] ^ (flips[i] ? 48'h20 : 48'h0),
                                masks[i] ? 48'h20 : 48'h0));
        end
    endtask

    task automatic run(input int s, input int nv);
        sel       = s;
        #0;
        g_prev_in = m_dut_in;
        num_vec   = (AW + 1)'(nv);
        if (s != 0) start2 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start1      = 1'b0;
        start2      = 1'b0;
        g_sig_start = m_sig;
        g_busy      = m_busy;
        g_cycles    = 1;
        while (!m_done && g_cycles < 3000) begin
            @(posedge clk);
            #1;
            g_cycles++;
            if (m_busy) g_busy = 1'b1;
        end
        if (!m_done) chk("run_timeout", 0, 1);
    endtask

    // Reference: each vector's loopback response is its own stimulus LSBs.
    task automatic check_run(input int s, input int nv, input string tag);
        int                depth;
        int                emax;
        int                n;
        int                err;
        int                ff;
        bit                ffv;
        logic [WD-1:0]     e;
        logic [RESP_W-1:0] resp, ex, mk, sg;
        logic [STIM_W-1:0] last_in;
        depth   = (s != 0) ? DEPTH2 : DEPTH;
        emax    = (s != 0) ? 3 : 65535;
        n       = (nv > depth) ? depth : nv;
        err     = 0;
        ff      = 0;
        ffv     = 1'b0;
        sg      = '0;
        last_in = g_prev_in;
        for (int i = 0; i < n; i++) begin
            e       = (s != 0) ? mdl2[i] : mdl1[i];
            last_in = e[STIM_W-1:0];
            resp    = e[RESP_W-1:0];
            ex      = e[STIM_W +: RESP_W];
            mk      = e[STIM_W+RESP_W +: RESP_W];
            if (((resp ^ ex) & ~mk) != '0) begin
                if (err < emax) err++;
                if (!ffv) begin
                    ffv = 1'b1;
                    ff  = i;
                end
            end
            sg = ((sg << 1) | (sg >> (RESP_W - 1))) ^ (resp & ~mk);
        end
        chk({tag, "_cycles"}, g_cycles, n * 6 + 1);
        chk({tag, "_err"}, m_err, err);
        chk({tag, "_ffv"}, m_ffv, ffv);
        chk({tag, "_ff"}, m_ff, ff);
        chk({tag, "_pass"}, {m_done, m_pass}, {1'b1, err == 0});
        chk({tag, "_busy_seen"}, g_busy, n > 0);
        chk({tag, "_busy_end"}, m_busy, 0);
        chk({tag, "_dut_in"}, m_dut_in, last_in);
        chk({tag, "_cur"}, m_cur, (n > 0) ? n - 1 : 0);
`ifdef MORPHLE_VCHK_SIG_EN
        chk({tag, "_sig_clr"}, g_sig_start, 0);
        chk({tag, "_sig"}, m_sig, sg);
`endif
    endtask

    initial begin
        logic [31:0]       r1, r2;
        logic [STIM_W-1:0] st;
        logic [RESP_W-1:0] fl, mk;
        int                nv;

        rows[0] = '{4,  16'h0000, 16'h0000, 0, 0,  1'b0, 1'b1, 25};
        rows[1] = '{4,  16'h0004, 16'h0000, 1, 2,  1'b1, 1'b0, 25};
        rows[2] = '{4,  16'h0004, 16'h0004, 0, 0,  1'b0, 1'b1, 25};
        rows[3] = '{0,  16'h0000, 16'h0000, 0, 0,  1'b0, 1'b1, 1};
        rows[4] = '{17, 16'h8000, 16'h0000, 1, 15, 1'b1, 1'b0, 97};
        rows[5] = '{16, 16'h020A, 16'h0000, 3, 1,  1'b1, 1'b0, 97};
        rows[6] = '{1,  16'h0001, 16'h0000, 1, 0,  1'b1, 1'b0, 7};
        rows[7] = '{0,  16'hFFFF, 16'h0000, 0, 0,  1'b0, 1'b1, 1};

        rst = 1'b1; wr_en1 = 0; wr_en2 = 0; start1 = 0; start2 = 0;
        wr_addr = '0; wr_data = '0; num_vec = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dut_in", dut_in1, 0);
        chk("reset_flags", {busy1, done1, pass1, ffv1}, 4'b0000);
        chk("reset_err", err1, 0);
        chk("reset_ff_cur", {ff1, cur1}, 8'h00);
        rst = 1'b0;

        // Table-driven runs on the main instance.
        for (int r = 0; r < 8; r++) begin
            load(0, DEPTH, rows[r].flips, rows[r].masks);
            run(0, rows[r].nv);
            chk($sformatf("tab%0d_cycles", r), g_cycles, rows[r].e_cyc);
            chk($sformatf("tab%0d_err", r), m_err, rows[r].e_err);
            chk($sformatf("tab%0d_ff", r), {m_ffv, m_ff}, {rows[r].e_ffv, 4'(rows[r].e_ff)});
            chk($sformatf("tab%0d_pass", r), {m_done, m_pass}, {1'b1, rows[r].e_pass});
            check_run(0, rows[r].nv, $sformatf("tab%0d", r));
        end

        // Reset during SETTLE of vector 1, then a clean rerun.
        load(0, 4, 16'h0005, 16'h0000);
        sel = 0;
        num_vec = 5'd4;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("rst_pre_err", err1, 1);
        chk("rst_pre_dut_in", dut_in1, stim_of(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_flags", {busy1, done1, pass1, ffv1}, 4'b0000);
        chk("rst_mid_dut_in", dut_in1, 0);
        chk("rst_mid_err", err1, 0);
        chk("rst_mid_cur", cur1, 0);
        run(0, 4);
        chk("rst_rerun_err", err1, 2);
        check_run(0, 4, "rst_rerun");

        // start and wr_en pulses during a run are ignored.
        load(0, 4, 16'h0004, 16'h0000);
        num_vec = 5'd4;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        g_cycles = 1;
        while (!done1 && g_cycles < 200) begin
            if (g_cycles == 3) begin
                start1 = 1'b1; num_vec = 5'd1;
            end
            if (g_cycles == 10) begin
                wr_en1 = 1'b1; wr_addr = 4'd2;
                st = stim_of(2);
                wr_data = mkw(st, st[RESP_W-1:0], '0);
            end
            if (g_cycles == 14) begin
                wr_en1 = 1'b1; wr_addr = 4'd0;
                st = stim_of(0);
                wr_data = mkw(st, ~st[RESP_W-1:0], '0);
            end
            @(posedge clk);
            #1;
            start1 = 1'b0;
            wr_en1 = 1'b0;
            g_cycles++;
        end
        chk("dist_cycles", g_cycles, 25);
        chk("dist_err", err1, 1);
        chk("dist_ff", {ffv1, ff1}, {1'b1, 4'd2});
        run(0, 4);
        check_run(0, 4, "dist_rerun");

        // Error counter saturation on the ERR_W=2 instance.
        load(1, DEPTH2, 16'h003E, 16'h0000);
        run(1, 6);
        chk("sat_err", m_err, 3);
        chk("sat_ff", m_ff, 1);
        check_run(1, 6, "sat");
        run(1, 9);
        check_run(1, 9, "sat_full");

        // Randomised vector sets checked against the reference.
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < DEPTH; i++) begin
                r1 = $urandom;
                r2 = $urandom;
                st = {r2[19:0], r1};
                r1 = $urandom;
                r2 = $urandom;
                case ($urandom % 3)
                    0:       fl = '0;
                    1:       fl = 48'h1 << ($urandom % 48);
                    default: fl = {r2[15:0], r1};
                endcase
                r1 = $urandom;
                r2 = $urandom;
                case ($urandom % 3)
                    0:       mk = '0;
                    1:       mk = {r2[15:0], r1} & {$urandom, $urandom};
                    default: mk = (fl != '0 && r1[0]) ? fl : '0;
                endcase
                write_vec(0, i, mkw(st, st[RESP_W-1:0] ^ fl, mk));
            end
            nv = $urandom_range(0, DEPTH + 1);
            run(0, nv);
            check_run(0, nv, $sformatf("rnd%0d", it));
        end

`ifdef MORPHLE_VCHK_SIG_EN
        write_vec(0, 0, mkw(52'h1, 48'h1, '0));
        write_vec(0, 1, mkw(52'h2, 48'h2, '0));
        run(0, 2);
        chk("sig_two_const", m_sig, 48'h0);
        check_run(0, 2, "sig_two");
        run(0, 1);
        chk("sig_one_const", m_sig, 48'h1);
        check_run(0, 1, "sig_one");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
